// File: rtl/mem_stage_ctrl.sv
// Memory-access pipeline stage: drives a req/ack data memory, stalls on wait states,
// aborts on timeout, resolves branches and loads the MEM/WB pipeline register.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  EX_MEM_Rd,
    input  logic [63:0] EX_MEM_ALU,
    input  logic [63:0] EX_MEM_MUX_FB,
    input  logic [63:0] EX_MEM_Adder,
    input  logic        EX_MEM_zero,
    input  logic        EX_MEM_Great,
    input  logic        EX_MEM_BranchEq,
    input  logic        EX_MEM_BranchGt,
    input  logic        EX_MEM_MemRead,
    input  logic        EX_MEM_MemWrite,
    input  logic        EX_MEM_RegWrite,
    input  logic        EX_MEM_MemtoReg,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [63:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem_err,
    output logic        PCSrc,
    output logic [63:0] BranchTarget,
    output logic [4:0]  MEM_WB_Rd,
    output logic [63:0] MEM_WB_ReadData,
    output logic [63:0] MEM_WB_ALU,
    output logic        MEM_WB_RegWrite,
    output logic        MEM_WB_MemtoReg
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t             state, next_state;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [63:0]        lat_addr, lat_wdata;
    logic               lat_we;
    logic               latch_en;
    logic               timeout;
    logic               done_read;
    logic               access;

    assign access       = EX_MEM_MemRead | EX_MEM_MemWrite;
    assign BranchTarget = EX_MEM_Adder;

    // Next state, memory interface and stall/branch decode
    always_comb begin
        next_state = state;
        cnt_nxt    = cnt;
        latch_en   = 1'b0;
        timeout    = 1'b0;
        done_read  = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = EX_MEM_ALU;
        dmem_wdata = EX_MEM_MUX_FB;
        mem_stall  = 1'b0;
        PCSrc      = 1'b0;
        case (state)
            S_WAIT: begin
                dmem_req   = 1'b1;
                dmem_we    = lat_we;
                dmem_addr  = lat_addr;
                dmem_wdata = lat_wdata;
                if (dmem_ack) begin
                    done_read  = ~lat_we;
                    next_state = S_IDLE;
                    cnt_nxt    = '0;
                end else begin
                    mem_stall = 1'b1;
                    // Ack has priority over the final timeout cycle
                    if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        timeout    = 1'b1;
                        next_state = S_IDLE;
                        cnt_nxt    = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                dmem_we = EX_MEM_MemWrite & ~EX_MEM_MemRead;
                PCSrc   = (EX_MEM_BranchEq & EX_MEM_zero) | (EX_MEM_BranchGt & EX_MEM_Great);
                if (access) begin
                    dmem_req = 1'b1;
                    if (dmem_ack) begin
                        done_read = EX_MEM_MemRead;
                    end else begin
                        mem_stall  = 1'b1;
                        latch_en   = 1'b1;
                        next_state = S_WAIT;
                        cnt_nxt    = CNT_W'(1);
                    end
                end
            end
        endcase
        // Request withdrawn immediately while reset is asserted
        if (!reset) begin
            dmem_req  = 1'b0;
            mem_stall = 1'b0;
            PCSrc     = 1'b0;
        end
    end

    // State, timeout counter and access latches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= cnt_nxt;
            if (latch_en) begin
                lat_addr  <= EX_MEM_ALU;
                lat_wdata <= EX_MEM_MUX_FB;
                lat_we    <= EX_MEM_MemWrite & ~EX_MEM_MemRead;
            end
        end
    end

    // MEM/WB register: bubble on stall, cleared data on timeout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            MEM_WB_Rd       <= '0;
            MEM_WB_ReadData <= '0;
            MEM_WB_ALU      <= '0;
            MEM_WB_RegWrite <= 1'b0;
            MEM_WB_MemtoReg <= 1'b0;
            mem_err         <= 1'b0;
        end else begin
            mem_err <= timeout;
            if (timeout) begin
                MEM_WB_RegWrite <= 1'b0;
                MEM_WB_ReadData <= '0;
            end else if (mem_stall) begin
                MEM_WB_RegWrite <= 1'b0;
            end else begin
                MEM_WB_Rd       <= EX_MEM_Rd;
                MEM_WB_ALU      <= EX_MEM_ALU;
                MEM_WB_MemtoReg <= EX_MEM_MemtoReg;
                MEM_WB_RegWrite <= EX_MEM_RegWrite;
                MEM_WB_ReadData <= done_read ? dmem_rdata : 64'd0;
            end
        end
    end

endmodule
